fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, meaning the first fetch address after reset (word-aligned).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port imem_addr, output, 32, the current PC driven to the instruction memory Address input.
REQ-005 SHALL have port imem_instr, input, 32, the combinational instruction-memory read data for imem_addr, valid in the same cycle.
REQ-006 SHALL have port if_valid, output, 1, meaning the fetch output register holds an instruction for decode.
REQ-007 SHALL have port if_instr, output, 32, the registered instruction.
REQ-008 SHALL have port if_pc, output, 32, the address of if_instr.
REQ-009 SHALL have port if_pc_plus4, output, 32, equal to if_pc+4 (mod 2^32).
REQ-010 SHALL have port id_ready, input, 1, meaning decode accepts if_instr this cycle.
REQ-011 SHALL have port redirect_valid, input, 1, a branch/jump/jr request.
REQ-012 SHALL have port redirect_target, input, 32, the new PC when redirect_valid=1.
REQ-013 SHALL have port addr_err, output, 1, a sticky flag for a misaligned redirect target.
REQ-014 SHALL have port fetch_count, output, 32, the number of instructions loaded into the output register since reset.

Function
REQ-015 SHALL implement states RUN and HALT; reset enters RUN.
REQ-016 In RUN the output register SHALL load when (!if_valid || id_ready) and redirect_valid=0: if_instr<=imem_instr, if_pc<=PC, if_valid<=1, PC<=PC+4, fetch_count+1.
REQ-017 When the load condition is false, PC, if_instr, if_pc and if_valid SHALL hold (back-pressure); if_instr SHALL stay stable while if_valid=1 and id_ready=0.
REQ-018 Fetch-to-output latency SHALL be one cycle: the PC presented in cycle N appears on if_instr/if_pc in cycle N+1.
REQ-019 Redirect SHALL have priority over loading and back-pressure: with aligned redirect_target, PC<=redirect_target and if_valid<=0, whatever the value of id_ready.
REQ-020 A redirect with redirect_target[1:0]!=0 SHALL set addr_err<=1, set if_valid<=0, leave PC unchanged, and enter HALT.
REQ-021 In HALT, if_valid SHALL be 0, PC and fetch_count SHALL hold, and redirect_valid SHALL be ignored; only reset exits HALT.
REQ-022 PC increment SHALL wrap 32'hFFFFFFFC -> 32'h00000000 with no flag.
REQ-023 fetch_count SHALL wrap modulo 2^32.
REQ-024 imem_addr SHALL equal the PC register at all times (combinational from register, no logic in path).

Reset
REQ-025 On reset=1 at a clock edge: PC<=RESET_PC, if_valid<=0, if_instr<=0, if_pc<=0, addr_err<=0, fetch_count<=0, state<=RUN; this applies mid-operation and in HALT.
REQ-026 In the cycle after reset deasserts, imem_addr SHALL equal RESET_PC and if_valid SHALL be 0.

Structure
REQ-027 A shared package SHALL hold the state encoding (RUN, HALT) and constants WORD_BYTES=4 and the default RESET_PC.
REQ-028 The output register and handshake SHALL be a sub-module fetch_buffer (1-entry valid/ready register with flush input); PC, FSM and counter stay in fetch_unit.

Verification
REQ-029 Reset is released with the 19-word test program in instruction memory and id_ready=1 -> cycle 1: imem_addr=0, if_valid=0; cycle 2: if_valid=1, if_instr=32'h20040005, if_pc=0; cycle 3: if_instr=32'h00001026, if_pc=4.
REQ-030 id_ready=0 for 3 cycles while if_pc=4 -> if_instr holds 32'h00001026, imem_addr holds 8, fetch_count does not change; on release if_instr=32'h0c100004.
REQ-031 redirect_valid=1 with target 32'h10 while id_ready=0 -> next cycle if_valid=0 and imem_addr=32'h10; the cycle after, if_instr=32'h23bdfff8, if_pc=32'h10, if_pc_plus4=32'h14.
REQ-032 redirect_target=32'h12 -> addr_err=1, if_valid=0, PC frozen; a later aligned redirect to 0 is ignored; reset clears addr_err and fetch resumes at 0.
REQ-033 Reset asserted mid-stream at if_pc=32'h2C -> next cycle if_valid=0, imem_addr=0, fetch_count=0.
REQ-034 RESET_PC=32'hFFFFFFFC -> after the first load imem_addr=0 and addr_err=0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared definitions for the instruction fetch stage: FSM state encoding,
// fetch stride and default reset PC, plus a small alignment helper.
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

    // Fetch stage operating states; HALT is only left through reset.
    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

    // Bytes per instruction word (PC stride).
    localparam logic [31:0] WORD_BYTES       = 32'd4;

    // Default first fetch address after reset.
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // True when an address is aligned to a 32-bit instruction word.
    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage : fetch_unit_pkg

// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
// One-entry valid/ready output register between fetch and decode.
//
// Ports
//   clk, reset     : clock and synchronous active-high reset
//   i_flush        : drop the held entry (highest priority after reset)
//   i_load_valid   : a new instruction is offered for loading
//   i_instr        : instruction word to load
//   i_pc           : address of i_instr
//   i_pc_plus4     : i_pc + 4, stored alongside to keep the output registered
//   i_ready        : downstream consumes o_instr this cycle when o_valid=1
//   o_valid        : register holds an instruction
//   o_instr        : registered instruction
//   o_pc           : registered instruction address
//   o_pc_plus4     : registered instruction address + 4
//   o_can_load     : register is empty or being drained this cycle
// -----------------------------------------------------------------------------
module fetch_buffer
    import fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_flush,
    input  logic        i_load_valid,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_pc_plus4,
    input  logic        i_ready,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic        o_can_load
);

    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic [31:0] r_pc_plus4;
    logic        w_can_load;

    // Space is available when empty or when the current entry leaves now.
    assign w_can_load = (~r_valid) | i_ready;

    // Output register: reset, flush, load, drain, or hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid    <= 1'b0;
            r_instr    <= 32'h0000_0000;
            r_pc       <= 32'h0000_0000;
            // Keeps o_pc_plus4 == o_pc + 4 even while empty after reset.
            r_pc_plus4 <= WORD_BYTES;
        end else if (i_flush) begin
            // Data is kept; only the valid bit is dropped.
            r_valid    <= 1'b0;
        end else if (i_load_valid && w_can_load) begin
            r_valid    <= 1'b1;
            r_instr    <= i_instr;
            r_pc       <= i_pc;
            r_pc_plus4 <= i_pc_plus4;
        end else if (i_ready) begin
            r_valid    <= 1'b0;
        end else begin
            r_valid    <= r_valid;
        end
    end

    assign o_valid    = r_valid;
    assign o_instr    = r_instr;
    assign o_pc       = r_pc;
    assign o_pc_plus4 = r_pc_plus4;
    assign o_can_load = w_can_load;

endmodule : fetch_buffer

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage: owns the PC, a RUN/HALT FSM and a load counter,
// and feeds a one-entry output register (fetch_buffer) towards decode.
// Redirects override both loading and back-pressure; a misaligned redirect
// target raises a sticky error and freezes the stage until reset.
//
// Parameters
//   RESET_PC        : first fetch address after reset (word-aligned)
// Ports
//   clk, reset      : clock and synchronous active-high reset
//   imem_addr       : current PC to instruction memory
//   imem_instr      : combinational read data for imem_addr
//   if_valid        : output register holds an instruction
//   if_instr        : registered instruction
//   if_pc           : address of if_instr
//   if_pc_plus4     : if_pc + 4 (mod 2^32)
//   id_ready        : decode accepts if_instr this cycle
//   redirect_valid  : branch/jump request
//   redirect_target : new PC when redirect_valid=1
//   addr_err        : sticky misaligned-redirect flag
//   fetch_count     : instructions loaded into the output register
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)(
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    input  logic        id_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        addr_err,
    output logic [31:0] fetch_count
);

    fetch_state_e r_state;
    fetch_state_e w_state_next;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_next;
    logic [31:0]  w_pc_plus4;
    logic [31:0]  r_count;
    logic [31:0]  w_count_next;
    logic         r_addr_err;
    logic         w_addr_err_next;
    logic         w_flush;
    logic         w_load;
    logic         w_can_load;

    // Natural 32-bit wrap gives FFFFFFFC -> 00000000.
    assign w_pc_plus4 = r_pc + WORD_BYTES;

    // State, PC, counter and error flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_PC;
            r_count    <= 32'h0000_0000;
            r_addr_err <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_count    <= w_count_next;
            r_addr_err <= w_addr_err_next;
        end
    end

    // Next-state logic: redirect beats load, load only when buffer has room.
    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_count_next    = r_count;
        w_addr_err_next = r_addr_err;
        w_flush         = 1'b0;
        w_load          = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (redirect_valid) begin
                    w_flush = 1'b1;
                    if (is_word_aligned(redirect_target)) begin
                        w_pc_next = redirect_target;
                    end else begin
                        // PC is left where it was so the fault point is visible.
                        w_addr_err_next = 1'b1;
                        w_state_next    = ST_HALT;
                    end
                end else if (w_can_load) begin
                    w_load       = 1'b1;
                    w_pc_next    = w_pc_plus4;
                    w_count_next = r_count + 32'd1;
                end else begin
                    w_load = 1'b0;
                end
            end
            ST_HALT: begin
                // Keep the output register empty; redirects are ignored.
                w_flush = 1'b1;
            end
            default: begin
                w_flush      = 1'b1;
                w_state_next = ST_HALT;
            end
        endcase
    end

    fetch_buffer u_fetch_buffer (
        .clk          (clk),
        .reset        (reset),
        .i_flush      (w_flush),
        .i_load_valid (w_load),
        .i_instr      (imem_instr),
        .i_pc         (r_pc),
        .i_pc_plus4   (w_pc_plus4),
        .i_ready      (id_ready),
        .o_valid      (if_valid),
        .o_instr      (if_instr),
        .o_pc         (if_pc),
        .o_pc_plus4   (if_pc_plus4),
        .o_can_load   (w_can_load)
    );

    assign imem_addr   = r_pc;
    assign addr_err    = r_addr_err;
    assign fetch_count = r_count;

endmodule : fetch_unit
